serial_sub: RTL

//  Parametrised digit-serial unsigned subtractor: diff = a - b, computed DIGIT bits per clock.

---
 rtl/serial_sub.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Digit-serial unsigned subtractor, diff = a - b, DIGIT bits per
//               clock. A start/busy/done handshake fronts the datapath.
//               Result is WIDTH+1 bits: {final borrow, (a-b) mod 2^WIDTH}.
//
//               Optional build macro SERIAL_SUB_SAT_EN: when defined, a final
//               borrow clamps the low WIDTH bits to zero while the borrow
//               flag stays set. Latency and handshake are unchanged.
//
// Ports       : clk    in   1        rising-edge clock
//               rst    in   1        asynchronous active-high reset
//               start  in   1        request; a/b sampled on the accept edge
//               a      in   WIDTH    minuend (unsigned)
//               b      in   WIDTH    subtrahend (unsigned)
//               busy   out  1        operation in progress
//               done   out  1        one-cycle pulse, diff holds new result
//               diff   out  WIDTH+1  {borrow, (a-b) mod 2^WIDTH}
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
);

    localparam int c_ndig = WIDTH / DIGIT;
    localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_borrow;
    logic [c_cw-1:0]   r_cnt;

    logic              w_load;
    logic              w_last;
    logic [DIGIT:0]    w_dsub;
    logic [WIDTH-1:0]  w_digit_ext;
    logic [WIDTH-1:0]  w_res_next;
    logic [WIDTH:0]    w_final;

    // A new request is taken whenever the engine is not running; this covers
    // both IDLE and the back-to-back case out of DONE.
    assign w_load = start && (r_state != S_RUN);
    assign w_last = (r_state == S_RUN) && (r_cnt == c_last);

    // One extra bit on the digit subtraction captures the borrow out; the
    // borrow chain within the digit stays combinational.
    assign w_dsub = {1'b0, r_a[DIGIT-1:0]}
                  - {1'b0, r_b[DIGIT-1:0]}
                  - {{DIGIT{1'b0}}, r_borrow};

    // Result digits enter at the top and move down, so after c_ndig steps the
    // first (least significant) digit sits at bit 0.
    assign w_digit_ext = WIDTH'(w_dsub[DIGIT-1:0]);
    assign w_res_next  = (r_res >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));

`ifdef SERIAL_SUB_SAT_EN
    assign w_final = w_dsub[DIGIT] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, w_res_next};
`else
    assign w_final = {w_dsub[DIGIT], w_res_next};
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
        end else if (w_load) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_res    <= w_res_next;
            r_borrow <= w_dsub[DIGIT];
            r_cnt    <= r_cnt + 1'b1;
            // diff only changes on completion, so an aborted run never
            // exposes a partial result.
            if (w_last) begin
                diff <= w_final;
            end
        end
    end

endmodule
`default_nettype wire
